// File: rtl/fp_pkg.sv
// Shared constants, encodings and small helpers for the sequential single-precision divider.
package fp_pkg;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned WORD_W = EXP_W + MAN_W + 1;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned QBITS  = MAN_W + 3;
  localparam int unsigned LZ_W   = $clog2(SIG_W + 1);
  localparam int unsigned CNT_W  = $clog2(QBITS);
  localparam int unsigned SEXP_W = EXP_W + 3;
  localparam int          BIAS   = (1 << (EXP_W - 1)) - 1;

  localparam logic [WORD_W-1:0] NAN_OUT = '1;
  localparam logic [EXP_W-1:0]  EXP_MAX = '1;

  typedef enum logic [2:0] {IDLE, UNPACK, DIV, ROUND, DONE} state_t;
  typedef enum logic [2:0] {CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_NAN} fclass_t;

  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_NV = 4;

  function automatic fclass_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return (f == '0) ? CLS_ZERO : CLS_SUB;
    if (e == '1) return (f == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  // Subnormals sit at exponent 1; the normalising shift lowers it further.
  function automatic logic signed [SEXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e,
                                                       input logic [LZ_W-1:0]  lz);
    logic [EXP_W-1:0] e_adj;
    e_adj = (e == '0) ? EXP_W'(1) : e;
    return $signed({{(SEXP_W-EXP_W){1'b0}}, e_adj}) - $signed({{(SEXP_W-LZ_W){1'b0}}, lz});
  endfunction
endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for fp_div_seq; o_flags exists only with FP_DIV_FLAGS_EN.
interface fp_div_seq_if;
  import fp_pkg::*;

  logic              i_load;
  logic [WORD_W-1:0] i_a;
  logic [WORD_W-1:0] i_b;
  logic [WORD_W-1:0] o_res;
  logic              o_busy;
  logic              o_valid;
`ifdef FP_DIV_FLAGS_EN
  logic [FLAG_W-1:0] o_flags;

  modport master (output i_load, i_a, i_b, input o_res, o_busy, o_valid, o_flags);
  modport slave  (input i_load, i_a, i_b, output o_res, o_busy, o_valid, o_flags);
`else
  modport master (output i_load, i_a, i_b, input o_res, o_busy, o_valid);
  modport slave  (input i_load, i_a, i_b, output o_res, o_busy, o_valid);
`endif
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fp_lzc
  import fp_pkg::*;
#(
  parameter int unsigned W  = SIG_W,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  val,
  output logic [CW-1:0] cnt
);
  logic found;

  always_comb begin
    cnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found) begin
        if (val[W-1-i]) found = 1'b1;
        else            cnt   = cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single divider, restoring, one quotient bit per clock, RNE, fixed latency.
// Define FP_DIV_FLAGS_EN to add o_flags {invalid, div_by_zero, overflow, underflow, inexact}.
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  fp_div_seq_if.slave bus
);
  state_t                    state;
  logic [CNT_W-1:0]          div_cnt;
  logic [WORD_W-1:0]         a_q, b_q, res_q;
  fclass_t                   cls_a_q, cls_b_q;
  logic                      sign_q;
  logic signed [SEXP_W-1:0]  exp_q;
  logic [QBITS-1:0]          rem_q, quo_q;
  logic [SIG_W-1:0]          mb_q;

  logic [SIG_W-1:0]          sig_a, sig_b, ma_n, mb_n;
  logic [LZ_W-1:0]           lz_a, lz_b;
  logic signed [SEXP_W-1:0]  exp_calc;

  always_comb begin
    sig_a    = {|a_q[WORD_W-2:MAN_W], a_q[MAN_W-1:0]};
    sig_b    = {|b_q[WORD_W-2:MAN_W], b_q[MAN_W-1:0]};
    ma_n     = sig_a << lz_a;
    mb_n     = sig_b << lz_b;
    exp_calc = eff_exp(a_q[WORD_W-2:MAN_W], lz_a) - eff_exp(b_q[WORD_W-2:MAN_W], lz_b)
             + SEXP_W'(BIAS);
  end

  fp_lzc #(.W(SIG_W), .CW(LZ_W)) u_lzc_a (.val(sig_a), .cnt(lz_a));
  fp_lzc #(.W(SIG_W), .CW(LZ_W)) u_lzc_b (.val(sig_b), .cnt(lz_b));

  logic             ge;
  logic [QBITS-1:0] mb_ext, rem_next, quo_next;

  always_comb begin
    mb_ext   = {{(QBITS-SIG_W){1'b0}}, mb_q};
    ge       = (mb_ext <= rem_q);
    rem_next = (rem_q - (ge ? mb_ext : '0)) << 1;
    quo_next = {quo_q[QBITS-2:0], ge};
  end

  logic [QBITS-1:0]         qn;
  logic signed [SEXP_W-1:0] en;
  logic [SEXP_W-1:0]        sh;
  logic [2*QBITS-1:0]       ext;
  logic [EXP_W-1:0]         exp_field;
  logic [EXP_W+MAN_W-1:0]   packed_r;
  logic                     tiny, ovf_pre, ovf, guard, sticky, rnd;
  logic [WORD_W-1:0]        finite_res, res_next;
  logic                     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  // The quotient is shifted into the upper half of ext so that denormalisation
  // bits land in the lower half and collapse into sticky; a clamped shift past
  // the quotient width moves everything there.
  always_comb begin
    qn      = quo_q[QBITS-1] ? quo_q : (quo_q << 1);
    en      = quo_q[QBITS-1] ? exp_q : exp_q - SEXP_W'(1);
    tiny    = en[SEXP_W-1] || (en == '0);
    ovf_pre = !en[SEXP_W-1] && ((|en[SEXP_W-2:EXP_W]) || (&en[EXP_W-1:0]));
    sh      = tiny ? SEXP_W'(1) - en : '0;
    if (sh > SEXP_W'(QBITS + 1)) sh = SEXP_W'(QBITS + 1);
    ext       = {qn, {QBITS{1'b0}}} >> sh;
    guard     = ext[QBITS+1];
    sticky    = ext[QBITS] | (|ext[QBITS-1:0]) | (|rem_q);
    rnd       = guard & (sticky | ext[QBITS+2]);
    exp_field = ext[2*QBITS-1] ? en[EXP_W-1:0] : EXP_W'(0);
    packed_r  = {exp_field, ext[2*QBITS-2:QBITS+2]} + (EXP_W+MAN_W)'(rnd);
    ovf       = ovf_pre | (&packed_r[EXP_W+MAN_W-1:MAN_W]);
    finite_res = ovf ? {sign_q, EXP_MAX, {MAN_W{1'b0}}} : {sign_q, packed_r};

    a_nan  = (cls_a_q == CLS_NAN);
    b_nan  = (cls_b_q == CLS_NAN);
    a_inf  = (cls_a_q == CLS_INF);
    b_inf  = (cls_b_q == CLS_INF);
    a_zero = (cls_a_q == CLS_ZERO);
    b_zero = (cls_b_q == CLS_ZERO);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      res_next = NAN_OUT;
    else if (a_inf || b_zero)
      res_next = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
    else if (a_zero || b_inf)
      res_next = {sign_q, {(WORD_W-1){1'b0}}};
    else
      res_next = finite_res;
  end

`ifdef FP_DIV_FLAGS_EN
  logic [FLAG_W-1:0] flags_q, flags_next;

  always_comb begin
    flags_next = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      flags_next[FLAG_NV] = (a_zero && b_zero) || (a_inf && b_inf)
                          || (a_nan && !a_q[MAN_W-1]) || (b_nan && !b_q[MAN_W-1]);
    end else if (!a_inf && b_zero) begin
      flags_next[FLAG_DZ] = !a_zero;
    end else if (!a_inf && !a_zero && !b_inf) begin
      flags_next[FLAG_OF] = ovf;
      flags_next[FLAG_NX] = guard | sticky | ovf;
      flags_next[FLAG_UF] = tiny & (guard | sticky);
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cls_a_q     <= CLS_ZERO;
      cls_b_q     <= CLS_ZERO;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      mb_q        <= '0;
      bus.o_res   <= '0;
      bus.o_busy  <= 1'b0;
      bus.o_valid <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
      flags_q     <= '0;
      bus.o_flags <= '0;
`endif
    end else begin
      bus.o_valid <= 1'b0;
      case (state)
        IDLE: if (bus.i_load) begin
          a_q        <= bus.i_a;
          b_q        <= bus.i_b;
          bus.o_busy <= 1'b1;
          state      <= UNPACK;
        end
        UNPACK: begin
          cls_a_q <= classify(a_q[WORD_W-2:MAN_W], a_q[MAN_W-1:0]);
          cls_b_q <= classify(b_q[WORD_W-2:MAN_W], b_q[MAN_W-1:0]);
          sign_q  <= a_q[WORD_W-1] ^ b_q[WORD_W-1];
          exp_q   <= exp_calc;
          rem_q   <= {{(QBITS-SIG_W){1'b0}}, ma_n};
          mb_q    <= mb_n;
          quo_q   <= '0;
          div_cnt <= '0;
          state   <= DIV;
        end
        DIV: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          div_cnt <= div_cnt + CNT_W'(1);
          if (div_cnt == CNT_W'(QBITS - 1)) state <= ROUND;
        end
        ROUND: begin
          res_q   <= res_next;
`ifdef FP_DIV_FLAGS_EN
          flags_q <= flags_next;
`endif
          state   <= DONE;
        end
        DONE: begin
          bus.o_res   <= res_q;
          bus.o_valid <= 1'b1;
          bus.o_busy  <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
          bus.o_flags <= flags_q;
`endif
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed-vector bench for fp_div_seq: results, fixed latency, handshake and reset abort.
module tb_fp_div_seq;
  localparam int NV  = 19;
  localparam int LAT = 29;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fp_div_seq_if bus();

  fp_div_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] va [NV] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000001, 32'h00800000,
                           32'h7F7FFFFF, 32'h00000000, 32'h3F800000, 32'h7FC00000, 32'h7F800000,
                           32'h80000000, 32'h3F800000, 32'hFF800000, 32'h00000001, 32'h00000003,
                           32'h00FFFFFF, 32'h3F800000, 32'h3F800000, 32'h40000000};
  logic [31:0] vb [NV] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h3F000000, 32'h40000000,
                           32'h3F000000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h7F800000,
                           32'h3F800000, 32'h7F800000, 32'h40000000, 32'h40000000, 32'h40000000,
                           32'h40000000, 32'h00000001, 32'h00400000, 32'h00000000};
  logic [31:0] vr [NV] = '{32'h40400000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h00000002, 32'h00400000,
                           32'h7F800000, 32'hFFFFFFFF, 32'hFF800000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'h80000000, 32'h00000000, 32'hFF800000, 32'h00000000, 32'h00000002,
                           32'h00800000, 32'h7F800000, 32'h7F000000, 32'h7F800000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.i_a    = a;
    bus.i_b    = b;
    bus.i_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_load = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.o_valid && n < LAT + 10);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r);
    int n;
    start(a, b);
    check({tag, ".busy"}, 32'(bus.o_busy), 32'd1);
    wait_valid(n);
    check({tag, ".lat"}, n, LAT);
    check({tag, ".res"}, bus.o_res, r);
    check({tag, ".busy_end"}, 32'(bus.o_busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(bus.o_valid), 32'd0);
    check({tag, ".hold"}, bus.o_res, r);
  endtask

  initial begin
    int pulses;
    int lat;
    bus.i_load = 1'b0;
    bus.i_a    = '0;
    bus.i_b    = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.res", bus.o_res, 32'h0);
    check("rst.busy", 32'(bus.o_busy), 32'd0);
    check("rst.valid", 32'(bus.o_valid), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_op($sformatf("v%0d", i), va[i], vb[i], vr[i]);

    // second load during a busy operation must be dropped
    start(32'h40C00000, 32'h40000000);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.i_a    = 32'h3F800000;
    bus.i_b    = 32'h40400000;
    bus.i_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_load = 1'b0;
    pulses = 0;
    lat    = 0;
    for (int k = 6; k <= 70; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.o_valid) begin
        pulses++;
        if (lat == 0) lat = k;
      end
    end
    check("hs.pulses", pulses, 1);
    check("hs.lat", lat, LAT);
    check("hs.res", bus.o_res, 32'h40400000);
    check("hs.busy", 32'(bus.o_busy), 32'd0);

    // asynchronous reset in the middle of DIV aborts the operation
    start(32'h3F800000, 32'h40400000);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.res", bus.o_res, 32'h0);
    check("abort.busy", 32'(bus.o_busy), 32'd0);
    check("abort.valid", 32'(bus.o_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.o_valid) pulses++;
    end
    check("abort.no_valid", pulses, 0);
    check("abort.res_kept", bus.o_res, 32'h0);
    run_op("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
